md_issue: RTL and testbench

- Issue/interlock stage directly upstream of the multiply/divide unit (MD), in the E stage.
- Accepts MD-class instructions from the pipeline and drives MDOp/MDStart/A/B into MD.
- Stalls the pipeline while MD is busy, parking the blocked instruction in a one-entry slot and issuing it when MD frees.
- Also provides a saturating stall-cycle counter and a sticky divide-by-zero flag.

---
 rtl/md_pkg.sv | 39 +++
 rtl/md_issue_if.sv | 31 +++
 rtl/md_issue_sat_counter.sv | 35 +++
 rtl/md_issue.sv | 132 +++++++++++++
 tb/tb_md_issue.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/md_pkg.sv
// md_pkg: op codes, issue-stage FSM states and op classification helpers
// shared by the MD issue stage, the MD unit and the instruction decoder.
// Ports: none (package).
package md_pkg;

  // MD op codes as carried on InOp / MDOp
  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_MADD  = 4'd3;
  localparam logic [3:0] MD_MADDU = 4'd4;
  localparam logic [3:0] MD_MSUB  = 4'd5;
  localparam logic [3:0] MD_MSUBU = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;
  localparam logic [3:0] MD_MFHI  = 4'd9;
  localparam logic [3:0] MD_MFLO  = 4'd10;
  localparam logic [3:0] MD_DIV   = 4'd14;
  localparam logic [3:0] MD_DIVU  = 4'd15;

  // Issue-stage FSM states
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  // Ops that kick off a multi-cycle MD operation (MDStart=1)
  function automatic logic is_start_op(input logic [3:0] op);
    return ((op >= MD_MULT) && (op <= MD_MSUBU)) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  // Ops the issue stage acts on; 0 and the unused codes 11-13 are ignored
  function automatic logic is_md_op(input logic [3:0] op);
    return ((op >= MD_MULT) && (op <= MD_MFLO)) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_issue_if.sv
// md_issue_if: bundle of pipeline-side and MD-side signals of the MD issue stage.
// Ports: In* / Flush / ClrDivZero from the pipeline, MDBusy from MD;
//        MDOp/MDStart/A/B to MD, Stall/DivZero/StallCnt to the pipeline.
interface md_issue_if #(parameter int CNT_W = 32);
  logic             InValid;
  logic [3:0]       InOp;
  logic [31:0]      InA;
  logic [31:0]      InB;
  logic             Flush;
  logic             MDBusy;
  logic             ClrDivZero;
  logic [3:0]       MDOp;
  logic             MDStart;
  logic [31:0]      A;
  logic [31:0]      B;
  logic             Stall;
  logic             DivZero;
  logic [CNT_W-1:0] StallCnt;

  // Issue stage's view
  modport slave (
    input  InValid, InOp, InA, InB, Flush, MDBusy, ClrDivZero,
    output MDOp, MDStart, A, B, Stall, DivZero, StallCnt
  );

  // Pipeline / MD environment's view
  modport master (
    output InValid, InOp, InA, InB, Flush, MDBusy, ClrDivZero,
    input  MDOp, MDStart, A, B, Stall, DivZero, StallCnt
  );
endinterface

// File: rtl/md_issue_sat_counter.sv
// sat_counter: W-bit up counter that sticks at all-ones instead of wrapping.
// Ports: clk_i, rst_i (async, active-high), inc_i (count this edge),
//        clr_i (synchronous clear, wins over inc_i), cnt_o (current count).
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/md_issue.sv
// md_issue: E-stage issue/interlock in front of the multiply/divide unit.
// Ports: Clk, Rst (async, active-high); bus (md_issue_if.slave) carrying the
//        E instruction, Flush, MDBusy, ClrDivZero in and MDOp/MDStart/A/B,
//        Stall, DivZero, StallCnt out.
module md_issue
  import md_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input logic        Clk,
  input logic        Rst,
  md_issue_if.slave  bus
);

  logic [0:0]  state_q, state_d;
  logic [3:0]  slot_op_q, slot_op_d;
  logic [31:0] slot_a_q, slot_a_d;
  logic [31:0] slot_b_q, slot_b_d;
  logic        div_zero_q, div_zero_d;

  logic        md_class;
  logic [3:0]  op_c;
  logic [31:0] a_c, b_c;
  logic        start_c, stall_c;

  assign md_class = bus.InValid && is_md_op(bus.InOp);

  always_comb begin
    state_d   = state_q;
    slot_op_d = slot_op_q;
    slot_a_d  = slot_a_q;
    slot_b_d  = slot_b_q;
    op_c      = MD_NONE;
    a_c       = '0;
    b_c       = '0;
    start_c   = 1'b0;
    stall_c   = 1'b0;

    if (bus.Flush) begin
      // Kill the E instruction and any parked op; MD keeps whatever it started.
      state_d   = IDLE;
      slot_op_d = MD_NONE;
      slot_a_d  = '0;
      slot_b_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (md_class) begin
            if (!bus.MDBusy) begin
              // Same-cycle pass-through so mfhi/mflo results land this cycle.
              op_c    = bus.InOp;
              a_c     = bus.InA;
              b_c     = bus.InB;
              start_c = is_start_op(bus.InOp);
            end else begin
              // MD busy: park the op and freeze the pipeline. Every MD-class
              // op waits, which keeps HI/LO accesses in program order.
              stall_c   = 1'b1;
              slot_op_d = bus.InOp;
              slot_a_d  = bus.InA;
              slot_b_d  = bus.InB;
              state_d   = HOLD;
            end
          end
        end
        HOLD: begin
          if (bus.MDBusy) begin
            stall_c = 1'b1;
          end else begin
            // Issue from the slot, not from the inputs, and release the
            // pipeline; the held instruction retires at this edge.
            op_c      = slot_op_q;
            a_c       = slot_a_q;
            b_c       = slot_b_q;
            start_c   = is_start_op(slot_op_q);
            state_d   = IDLE;
            slot_op_d = MD_NONE;
            slot_a_d  = '0;
            slot_b_d  = '0;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Sticky divide-by-zero; a new occurrence beats a simultaneous clear.
  always_comb begin
    div_zero_d = div_zero_q;
    if (start_c && is_div_op(op_c) && (b_c == 32'd0)) begin
      div_zero_d = 1'b1;
    end else if (bus.ClrDivZero) begin
      div_zero_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= IDLE;
      slot_op_q  <= MD_NONE;
      slot_a_q   <= '0;
      slot_b_q   <= '0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_op_q  <= slot_op_d;
      slot_a_q   <= slot_a_d;
      slot_b_q   <= slot_b_d;
      div_zero_q <= div_zero_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (Clk),
    .rst_i (Rst),
    .inc_i (stall_c),
    .clr_i (1'b0),
    .cnt_o (bus.StallCnt)
  );

  // The outputs are combinational from the inputs, so hold them quiet for the
  // whole time Rst is high rather than only after the registers settle.
  assign bus.MDOp    = Rst ? MD_NONE : op_c;
  assign bus.A       = Rst ? 32'd0   : a_c;
  assign bus.B       = Rst ? 32'd0   : b_c;
  assign bus.MDStart = Rst ? 1'b0    : start_c;
  assign bus.Stall   = Rst ? 1'b0    : stall_c;
  assign bus.DivZero = div_zero_q;

endmodule

// File: tb/tb_md_issue.sv
module tb_md_issue;
  import md_pkg::*;

  localparam int CNT_W = 4;

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  md_issue_if #(.CNT_W(CNT_W)) bus();

  md_issue #(.CNT_W(CNT_W)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  // ---------------- behavioural MD unit ----------------
  int unsigned busy_cnt;
  logic [31:0] hi, lo, md_out;
  logic signed [63:0] sa, sb;
  logic [63:0] ua, ub;

  assign bus.MDBusy = (busy_cnt != 0);
  assign md_out = (bus.MDOp == MD_MFHI) ? hi : lo;
  assign sa = {{32{bus.A[31]}}, bus.A};
  assign sb = {{32{bus.B[31]}}, bus.B};
  assign ua = {32'd0, bus.A};
  assign ub = {32'd0, bus.B};

  always @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      busy_cnt <= 0;
      hi <= 32'd0;
      lo <= 32'd0;
    end else begin
      if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
      if (bus.MDStart) begin
        case (bus.MDOp)
          MD_MULT:  {hi, lo} <= sa * sb;
          MD_MULTU: {hi, lo} <= ua * ub;
          MD_MADD:  {hi, lo} <= {hi, lo} + sa * sb;
          MD_MADDU: {hi, lo} <= {hi, lo} + ua * ub;
          MD_MSUB:  {hi, lo} <= {hi, lo} - sa * sb;
          MD_MSUBU: {hi, lo} <= {hi, lo} - ua * ub;
          MD_DIV: if (bus.B != 32'd0) begin
            lo <= $signed(bus.A) / $signed(bus.B);
            hi <= $signed(bus.A) % $signed(bus.B);
          end
          MD_DIVU: if (bus.B != 32'd0) begin
            lo <= bus.A / bus.B;
            hi <= bus.A % bus.B;
          end
          default: ;
        endcase
        busy_cnt <= is_div_op(bus.MDOp) ? 10 : 5;
      end else if (bus.MDOp == MD_MTHI) begin
        hi <= bus.A;
      end else if (bus.MDOp == MD_MTLO) begin
        lo <= bus.A;
      end
    end
  end

  // ---------------- checking ----------------
  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        start;
    logic        chk_out;
    logic [31:0] out;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  task automatic push(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic chk_out, input logic [31:0] out);
    exp_t e;
    e.op = op; e.a = a; e.b = b; e.start = is_start_op(op);
    e.chk_out = chk_out; e.out = out;
    exp_q.push_back(e);
  endtask

  // Every op presented to MD must match the next expected issue, in order.
  always @(negedge Clk) begin
    if (!Rst && (bus.MDOp != MD_NONE)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_issue", 64'(bus.MDOp), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("issue_op",    64'(bus.MDOp),    64'(mon_e.op));
        check("issue_a",     64'(bus.A),       64'(mon_e.a));
        check("issue_b",     64'(bus.B),       64'(mon_e.b));
        check("issue_start", 64'(bus.MDStart), 64'(mon_e.start));
        if (mon_e.chk_out) check("md_out", 64'(md_out), 64'(mon_e.out));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.InValid = v;
    bus.InOp    = op;
    bus.InA     = a;
    bus.InB     = b;
  endtask

  task automatic wait_free();
    int n;
    n = 0;
    while (bus.MDBusy && (n < 30)) begin
      tick();
      n++;
    end
    check("md_free_timeout", 64'(bus.MDBusy), 64'd0);
  endtask

  // Waits out a stall from the current +4 sample point; returns stall cycles seen.
  task automatic count_stall(output int n);
    n = 0;
    while (bus.Stall && (n < 20)) begin
      tick();
      #3;
      n++;
    end
  endtask

  int n_st;

  initial begin
    Rst = 1'b0;
    bus.Flush = 1'b0;
    bus.ClrDivZero = 1'b0;
    drive(1'b0, MD_NONE, 32'd0, 32'd0);
    #1 Rst = 1'b1;
    #2;
    // reset state
    check("rst_stall",    64'(bus.Stall),    64'd0);
    check("rst_mdstart",  64'(bus.MDStart),  64'd0);
    check("rst_mdop",     64'(bus.MDOp),     64'd0);
    check("rst_a",        64'(bus.A),        64'd0);
    check("rst_b",        64'(bus.B),        64'd0);
    check("rst_divzero",  64'(bus.DivZero),  64'd0);
    check("rst_stallcnt", 64'(bus.StallCnt), 64'd0);
    check("rst_state",    64'(dut.state_q),  64'(IDLE));
    #9 Rst = 1'b0;
    tick();

    // idle pass-through, then back-to-back div parked behind the mult
    drive(1'b1, MD_MULT, 32'd3, 32'd5);
    push(MD_MULT, 32'd3, 32'd5, 1'b0, 32'd0);
    #3;
    check("pt_mdop",  64'(bus.MDOp),    64'(MD_MULT));
    check("pt_start", 64'(bus.MDStart), 64'd1);
    check("pt_stall", 64'(bus.Stall),   64'd0);
    tick();
    drive(1'b1, MD_DIV, 32'd7, 32'd2);
    push(MD_DIV, 32'd7, 32'd2, 1'b0, 32'd0);
    #3;
    check("b2b_stall0", 64'(bus.Stall),   64'd1);
    check("b2b_start0", 64'(bus.MDStart), 64'd0);
    check("b2b_mdop0",  64'(bus.MDOp),    64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      #3;
      check("b2b_stall_hold", 64'(bus.Stall), 64'd1);
      check("b2b_nostart",    64'(bus.MDStart), 64'd0);
    end
    tick();
    #3;
    check("b2b_issue_stall", 64'(bus.Stall),   64'd0);
    check("b2b_issue_start", 64'(bus.MDStart), 64'd1);
    check("b2b_issue_op",    64'(bus.MDOp),    64'(MD_DIV));
    tick();
    drive(1'b0, MD_NONE, 32'd0, 32'd0);
    #3;
    check("b2b_stallcnt", 64'(bus.StallCnt), 64'd5);
    check("b2b_hi", 64'(hi), 64'd1);
    check("b2b_lo", 64'(lo), 64'd3);
    wait_free();

    // mflo waits for a busy multu, then reads the fresh LO
    drive(1'b1, MD_MULTU, 32'hFFFF_FFFF, 32'd2);
    push(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, 32'd0);
    #3;
    check("multu_start", 64'(bus.MDStart), 64'd1);
    tick();
    drive(1'b1, MD_MFLO, 32'd0, 32'd0);
    push(MD_MFLO, 32'd0, 32'd0, 1'b1, 32'hFFFF_FFFE);
    #3;
    count_stall(n_st);
    check("mflo_stall_cycles", 64'(n_st), 64'd5);
    check("mflo_op",    64'(bus.MDOp),    64'(MD_MFLO));
    check("mflo_start", 64'(bus.MDStart), 64'd0);
    tick();
    drive(1'b0, MD_NONE, 32'd0, 32'd0);
    #3;
    check("mflo_stallcnt", 64'(bus.StallCnt), 64'd10);

    // flush while a div is parked: it must never reach MD
    drive(1'b1, MD_MULT, 32'd1, 32'd1);
    push(MD_MULT, 32'd1, 32'd1, 1'b0, 32'd0);
    tick();
    drive(1'b1, MD_DIV, 32'd4, 32'd2);
    #3;
    check("fl_park_stall", 64'(bus.Stall), 64'd1);
    tick();
    bus.Flush = 1'b1;
    #3;
    check("fl_stall", 64'(bus.Stall),   64'd0);
    check("fl_start", 64'(bus.MDStart), 64'd0);
    check("fl_mdop",  64'(bus.MDOp),    64'd0);
    tick();
    bus.Flush = 1'b0;
    drive(1'b0, MD_NONE, 32'd0, 32'd0);
    #3;
    check("fl_state",    64'(dut.state_q),  64'(IDLE));
    check("fl_stallcnt", 64'(bus.StallCnt), 64'd11);
    wait_free();

    // counter saturation: 11 + 5 stall cycles sticks at 15
    drive(1'b1, MD_MULT, 32'h0001_0000, 32'h0003_0000);
    push(MD_MULT, 32'h0001_0000, 32'h0003_0000, 1'b0, 32'd0);
    tick();
    drive(1'b1, MD_MFHI, 32'd0, 32'd0);
    push(MD_MFHI, 32'd0, 32'd0, 1'b1, 32'd3);
    #3;
    count_stall(n_st);
    check("mfhi_stall_cycles", 64'(n_st), 64'd5);
    tick();
    drive(1'b0, MD_NONE, 32'd0, 32'd0);
    #3;
    check("sat_stallcnt", 64'(bus.StallCnt), 64'd15);

    // divide by zero, set-over-clear, invalid op while busy, plain clear
    drive(1'b1, MD_DIVU, 32'd9, 32'd0);
    push(MD_DIVU, 32'd9, 32'd0, 1'b0, 32'd0);
    #3;
    check("dz_start",  64'(bus.MDStart), 64'd1);
    check("dz_before", 64'(bus.DivZero), 64'd0);
    tick();
    drive(1'b0, MD_NONE, 32'd0, 32'd0);
    #3;
    check("dz_set", 64'(bus.DivZero), 64'd1);
    wait_free();
    drive(1'b1, MD_DIV, 32'd5, 32'd0);
    bus.ClrDivZero = 1'b1;
    push(MD_DIV, 32'd5, 32'd0, 1'b0, 32'd0);
    #3;
    check("dz2_start", 64'(bus.MDStart), 64'd1);
    tick();
    bus.ClrDivZero = 1'b0;
    drive(1'b1, 4'd12, 32'd1, 32'd1);
    #3;
    check("dz_set_wins",  64'(bus.DivZero), 64'd1);
    check("inv_op_stall", 64'(bus.Stall),   64'd0);
    check("inv_op_mdop",  64'(bus.MDOp),    64'd0);
    check("inv_op_start", 64'(bus.MDStart), 64'd0);
    tick();
    drive(1'b0, MD_NONE, 32'd0, 32'd0);
    bus.ClrDivZero = 1'b1;
    tick();
    bus.ClrDivZero = 1'b0;
    #3;
    check("dz_clear", 64'(bus.DivZero), 64'd0);
    wait_free();

    // asynchronous reset in the middle of a HOLD
    drive(1'b1, MD_DIVU, 32'd1, 32'd0);
    push(MD_DIVU, 32'd1, 32'd0, 1'b0, 32'd0);
    tick();
    drive(1'b1, MD_MULT, 32'd6, 32'd7);
    #3;
    check("ar_park_stall", 64'(bus.Stall),   64'd1);
    check("ar_divzero",    64'(bus.DivZero), 64'd1);
    tick();
    #1 Rst = 1'b1;
    #1;
    check("ar_stall",    64'(bus.Stall),    64'd0);
    check("ar_start",    64'(bus.MDStart),  64'd0);
    check("ar_mdop",     64'(bus.MDOp),     64'd0);
    check("ar_stallcnt", 64'(bus.StallCnt), 64'd0);
    check("ar_divzero0", 64'(bus.DivZero),  64'd0);
    check("ar_state",    64'(dut.state_q),  64'(IDLE));
    drive(1'b0, MD_NONE, 32'd0, 32'd0);
    #4 Rst = 1'b0;
    tick();
    #3;
    check("ar_post_stall", 64'(bus.Stall), 64'd0);
    check("ar_post_cnt",   64'(bus.StallCnt), 64'd0);

    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Hard bound on run time in case something wedges.
  initial begin
    #50000;
    $display("FAIL global_timeout: observed time limit reached expected completion");
    $fatal(1, "timeout");
  end

endmodule
